// File: rtl/hpu_reset_sequencer_pkg.sv
// Shared types and constants for the HPU soft-reset sequencer.
package hpu_reset_sequencer_pkg;

  // Width of a domain index; also the width of err_dom.
  localparam int DOMAIN_IDX_W = 4;

  // Defaults shared with the register-interface top.
  localparam int DEFAULT_HOLD_CYCLES    = 16;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_HOLD,
    ST_RELEASE,
    ST_DONE
  } seq_state_e;

  // Counter width large enough to hold the larger of the two intervals.
  function automatic int cnt_width(input int hold_cycles, input int timeout_cycles);
    int max_val;
    max_val = (hold_cycles > timeout_cycles) ? hold_cycles : timeout_cycles;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/hpu_reset_sequencer_timer.sv
// Loadable saturating down-counter. expire_o flags the last cycle of a loaded
// interval: after loading N it is high during the Nth cycle following the load.
module hpu_reset_sequencer_timer
  import hpu_reset_sequencer_pkg::*;
#(
  parameter int CNT_W = 11
) (
  input  logic             cfg_clk,
  input  logic             cfg_rst,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] load_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, then load, otherwise count down and stick at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (start_i) begin
      cnt_d = load_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge cfg_clk or posedge cfg_rst) begin
    if (cfg_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/hpu_reset_sequencer.sv
// HPU soft-reset sequencer: asserts domain resets in order, holds, releases
// them in reverse order with per-ack timeouts, and reports completion.
module hpu_reset_sequencer
  import hpu_reset_sequencer_pkg::*;
#(
  parameter int DOMAIN_NB      = 4,
  parameter int HOLD_CYCLES    = DEFAULT_HOLD_CYCLES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                    cfg_clk,
  input  logic                    cfg_rst,
  input  logic                    hpu_reset,
  output logic                    hpu_reset_done,
  output logic [DOMAIN_NB-1:0]    dom_rst_req,
  input  logic [DOMAIN_NB-1:0]    dom_rst_ack,
  output logic                    busy,
  output logic                    err_timeout,
  output logic [DOMAIN_IDX_W-1:0] err_dom
);

  if (DOMAIN_NB < 1 || DOMAIN_NB > 16) begin : g_bad_domain_nb
    $fatal(1, "hpu_reset_sequencer: DOMAIN_NB must be in 1..16");
  end

  localparam int                      CNT_W     = cnt_width(HOLD_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]        HOLD_LOAD = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0]        TMO_LOAD  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [DOMAIN_IDX_W-1:0] LAST_IDX  = DOMAIN_IDX_W'(DOMAIN_NB - 1);

  seq_state_e              state_q, state_d;
  logic [DOMAIN_IDX_W-1:0] idx_q, idx_d;
  logic [DOMAIN_NB-1:0]    req_q, req_d;
  logic                    err_q, err_d;
  logic [DOMAIN_IDX_W-1:0] err_dom_q, err_dom_d;
  logic                    done_q;
  logic                    hpu_reset_q;

  logic                    ack_cur;
  logic                    timed_out;
  logic                    set_en;
  logic                    clr_en;
  logic [DOMAIN_IDX_W-1:0] bit_idx;
  logic                    tmr_start;
  logic                    tmr_clear;
  logic [CNT_W-1:0]        tmr_load;
  logic                    tmr_expire;

  // One timer serves both the HOLD interval and every ack-wait timeout.
  hpu_reset_sequencer_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .cfg_clk  (cfg_clk),
    .cfg_rst  (cfg_rst),
    .start_i  (tmr_start),
    .clear_i  (tmr_clear),
    .load_i   (tmr_load),
    .expire_o (tmr_expire)
  );

  // Select the ack of the domain currently being waited on.
  always_comb begin
    ack_cur = 1'b0;
    for (int j = 0; j < DOMAIN_NB; j++) begin
      if (idx_q == DOMAIN_IDX_W'(j)) begin
        ack_cur = dom_rst_ack[j];
      end
    end
  end

  // Sequencing FSM: next state, domain index, request vector and error capture.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    req_d     = req_q;
    err_d     = err_q;
    err_dom_d = err_dom_q;
    timed_out = 1'b0;
    set_en    = 1'b0;
    clr_en    = 1'b0;
    bit_idx   = idx_q;
    tmr_start = 1'b0;
    tmr_clear = 1'b0;
    tmr_load  = TMO_LOAD;

    case (state_q)
      ST_IDLE: begin
        // Only a fresh low-to-high level change starts a sequence.
        if (hpu_reset && !hpu_reset_q) begin
          state_d   = ST_ASSERT;
          idx_d     = '0;
          err_d     = 1'b0;
          err_dom_d = '0;
          set_en    = 1'b1;
          bit_idx   = '0;
          tmr_start = 1'b1;
        end
      end
      ST_ASSERT: begin
        if (ack_cur || tmr_expire) begin
          timed_out = !ack_cur;
          tmr_start = 1'b1;
          if (idx_q != LAST_IDX) begin
            idx_d   = idx_q + DOMAIN_IDX_W'(1);
            set_en  = 1'b1;
            bit_idx = idx_q + DOMAIN_IDX_W'(1);
          end else begin
            state_d  = ST_HOLD;
            tmr_load = HOLD_LOAD;
          end
        end
      end
      ST_HOLD: begin
        if (tmr_expire) begin
          state_d   = ST_RELEASE;
          idx_d     = LAST_IDX;
          clr_en    = 1'b1;
          bit_idx   = LAST_IDX;
          tmr_start = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!ack_cur || tmr_expire) begin
          timed_out = ack_cur;
          if (idx_q != '0) begin
            idx_d     = idx_q - DOMAIN_IDX_W'(1);
            clr_en    = 1'b1;
            bit_idx   = idx_q - DOMAIN_IDX_W'(1);
            tmr_start = 1'b1;
          end else begin
            state_d   = ST_DONE;
            tmr_clear = 1'b1;
          end
        end
      end
      ST_DONE: begin
        // Leave once the register bank has dropped its request.
        if (!hpu_reset) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Only the first timeout of a sequence is recorded.
    if (timed_out && !err_q) begin
      err_d     = 1'b1;
      err_dom_d = idx_q;
    end

    for (int j = 0; j < DOMAIN_NB; j++) begin
      if (bit_idx == DOMAIN_IDX_W'(j)) begin
        if (set_en) begin
          req_d[j] = 1'b1;
        end
        if (clr_en) begin
          req_d[j] = 1'b0;
        end
      end
    end
  end

  // State, request vector, error and completion registers.
  always_ff @(posedge cfg_clk or posedge cfg_rst) begin
    if (cfg_rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      req_q       <= '0;
      err_q       <= 1'b0;
      err_dom_q   <= '0;
      done_q      <= 1'b0;
      hpu_reset_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      req_q       <= req_d;
      err_q       <= err_d;
      err_dom_q   <= err_dom_d;
      done_q      <= (state_d == ST_DONE);
      hpu_reset_q <= hpu_reset;
    end
  end

  assign hpu_reset_done = done_q;
  assign dom_rst_req    = req_q;
  assign busy           = (state_q != ST_IDLE);
  assign err_timeout    = err_q;
  assign err_dom        = err_dom_q;

endmodule
